// File: rtl/memory_access.sv
// Memory stage: issues data-bus requests, aligns store lanes, extends load data and
// buffers a completed load result while the pipeline is frozen.
module memory_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] in_pc,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [63:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        freeze,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        stall_req,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic [63:0] out_wdata,
  output logic        out_misalign
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      stateQ, stateD;
  logic [63:0] bufQ, bufD;

  logic        isMem, misalign, memGo, complete, signExt;
  logic [1:0]  size;
  logic [2:0]  off;
  logic [2:0]  alignMask;
  logic [7:0]  laneMask;
  logic [63:0] shifted, extended, loadVal;

  assign size    = in_funct3[1:0];
  assign off     = in_addr[2:0];
  assign signExt = ~in_funct3[2];

  always_comb begin
    alignMask = 3'b000;
    laneMask  = 8'h01;
    unique case (size)
      2'd0: begin alignMask = 3'b000; laneMask = 8'h01; end
      2'd1: begin alignMask = 3'b001; laneMask = 8'h03; end
      2'd2: begin alignMask = 3'b011; laneMask = 8'h0F; end
      2'd3: begin alignMask = 3'b111; laneMask = 8'hFF; end
      default: ;
    endcase
  end

  assign isMem    = in_valid & (in_mem_read | in_mem_write);
  assign misalign = isMem & (|(off & alignMask));
  assign memGo    = isMem & ~misalign;

  // Bus returns the whole aligned doubleword; shift the addressed bytes down to bit 0.
  assign shifted = dresp_data >> {off, 3'b000};

  always_comb begin
    extended = shifted;
    unique case (size)
      2'd0: extended = {{56{signExt & shifted[7]}},  shifted[7:0]};
      2'd1: extended = {{48{signExt & shifted[15]}}, shifted[15:0]};
      2'd2: extended = {{32{signExt & shifted[31]}}, shifted[31:0]};
      2'd3: extended = shifted;
      default: ;
    endcase
  end

  assign complete = dresp_data_ok | (stateQ == StDone);
  assign loadVal  = (stateQ == StDone) ? bufQ : extended;

  assign dreq_valid  = memGo & (stateQ != StDone) & ~reset;
  assign dreq_addr   = in_addr;
  assign dreq_size   = {1'b0, size};
  assign dreq_strobe = (in_valid & in_mem_write) ? (laneMask << off) : 8'h00;
  assign dreq_data   = in_wdata << {off, 3'b000};

  assign stall_req     = memGo & ~complete;
  assign out_valid     = in_valid & ~stall_req;
  assign out_pc        = in_pc;
  assign out_rd        = in_rd;
  assign out_reg_write = in_reg_write;
  assign out_misalign  = misalign;

  always_comb begin
    if (misalign)         out_wdata = 64'h0;
    else if (in_mem_read) out_wdata = loadVal;
    else                  out_wdata = in_result;
  end

  always_comb begin
    stateD = stateQ;
    bufD   = bufQ;
    unique case (stateQ)
      StIdle, StWait: begin
        if (memGo) begin
          if (dresp_data_ok) begin
            // Hold the result if the downstream register cannot take it this cycle.
            if (freeze) begin
              stateD = StDone;
              bufD   = extended;
            end else begin
              stateD = StIdle;
            end
          end else begin
            stateD = StWait;
          end
        end else begin
          stateD = StIdle;
        end
      end
      StDone: begin
        if (!freeze) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
      bufQ   <= 64'h0;
    end else begin
      stateQ <= stateD;
      bufQ   <= bufD;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access: byte-level reference model plus directed literal checks.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write, freeze, dresp_data_ok;
  logic [63:0] in_pc, in_addr, in_wdata, in_result, dresp_data;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        dreq_valid, stall_req, out_valid, out_reg_write, out_misalign;
  logic [63:0] dreq_addr, dreq_data, out_pc, out_wdata;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [4:0]  out_rd;

  int total = 0;
  int passed = 0;

  // Model state: a finished load result held while the pipeline is frozen.
  bit          haveCap = 0;
  logic [63:0] capVal = '0;
  bit          retire;

  memory_access dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .freeze(freeze), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall_req(stall_req), .out_valid(out_valid), .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_wdata(out_wdata), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int nBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] extractLoad(input logic [63:0] resp, input logic [63:0] addr,
                                              input logic [2:0] f3);
    int n = nBytes(f3);
    int off = int'(addr % 8);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = resp[8*((off + i) % 8) +: 8];
    if (!f3[2] && v[8*n-1]) for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] strobeOf(input logic [63:0] addr, input logic [2:0] f3);
    int off = int'(addr % 8);
    logic [7:0] s = '0;
    for (int i = 0; i < nBytes(f3); i++) if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] laneData(input logic [63:0] addr, input logic [63:0] w);
    int off = int'(addr % 8);
    logic [63:0] d = '0;
    for (int j = off; j < 8; j++) d[8*j +: 8] = w[8*(j-off) +: 8];
    return d;
  endfunction

  function automatic bit isMisaligned(input logic [63:0] addr, input logic [2:0] f3);
    return (addr % 64'(nBytes(f3))) != 0;
  endfunction

  task automatic clearIn();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0; freeze = 0;
    dresp_data_ok = 0; in_pc = '0; in_addr = '0; in_wdata = '0; in_result = '0;
    dresp_data = '0; in_funct3 = '0; in_rd = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Compare every DUT output with the model, then advance the model past the coming edge.
  task automatic observe();
    bit isMem, mis, go, expStall, expValid, expDreq;
    logic [63:0] loadv, expW;
    @(negedge clk);
    isMem    = in_valid && (in_mem_read || in_mem_write);
    mis      = isMem && isMisaligned(in_addr, in_funct3);
    go       = isMem && !mis;
    expStall = go && !(dresp_data_ok || haveCap);
    expValid = in_valid && !expStall;
    expDreq  = go && !haveCap && !reset;
    loadv    = haveCap ? capVal : extractLoad(dresp_data, in_addr, in_funct3);
    expW     = mis ? 64'h0 : (in_mem_read ? loadv : in_result);
    chk("dreq_valid", 64'(dreq_valid), 64'(expDreq));
    chk("stall_req", 64'(stall_req), 64'(expStall));
    chk("out_valid", 64'(out_valid), 64'(expValid));
    chk("out_pc", out_pc, in_pc);
    chk("out_rd", 64'(out_rd), 64'(in_rd));
    chk("out_reg_write", 64'(out_reg_write), 64'(in_reg_write));
    if (in_valid) chk("out_misalign", 64'(out_misalign), 64'(mis));
    if (expValid) chk("out_wdata", out_wdata, expW);
    if (expDreq) begin
      chk("dreq_addr", dreq_addr, in_addr);
      chk("dreq_size", 64'(dreq_size), 64'(in_funct3[1:0]));
      chk("dreq_strobe", 64'(dreq_strobe), in_mem_write ? 64'(strobeOf(in_addr, in_funct3)) : 64'h0);
      if (in_mem_write) chk("dreq_data", dreq_data, laneData(in_addr, in_wdata));
    end
    if (reset) haveCap = 0;
    else if (haveCap) begin
      if (!freeze) haveCap = 0;
    end else if (go && dresp_data_ok && freeze) begin
      haveCap = 1;
      capVal  = extractLoad(dresp_data, in_addr, in_funct3);
    end
    retire = !freeze && !expStall;
  endtask

  task automatic setMem(input bit rd, input logic [2:0] f3, input logic [63:0] addr);
    in_valid = 1; in_mem_read = rd; in_mem_write = !rd; in_reg_write = rd;
    in_funct3 = f3; in_addr = addr; in_pc = 64'h8000_0000 + addr; in_rd = 5'd7;
  endtask

  initial begin
    int k, lat, kind;
    bit ok;
    clearIn();
    reset = 1;
    repeat (2) begin nextCycle(); observe(); end
    chk("reset out_valid", 64'(out_valid), 64'h0);
    chk("reset dreq_valid", 64'(dreq_valid), 64'h0);
    nextCycle(); reset = 0;

    // ALU pass-through
    in_valid = 1; in_result = 64'h5; in_rd = 5'd3; in_reg_write = 1; in_pc = 64'h100;
    observe();
    chk("add out_valid", 64'(out_valid), 64'h1);
    chk("add out_wdata", out_wdata, 64'h5);
    chk("add dreq_valid", 64'(dreq_valid), 64'h0);
    chk("add stall", 64'(stall_req), 64'h0);

    // LB with response on the third cycle
    nextCycle(); clearIn(); setMem(1, 3'b000, 64'h1003);
    dresp_data = 64'h0000_0000_8000_0000;
    observe(); chk("lb stall c1", 64'(stall_req), 64'h1);
    nextCycle(); observe(); chk("lb stall c2", 64'(stall_req), 64'h1);
    nextCycle(); dresp_data_ok = 1; observe();
    chk("lb stall c3", 64'(stall_req), 64'h0);
    chk("lb wdata", out_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    nextCycle(); in_funct3 = 3'b100; observe();
    chk("lbu wdata", out_wdata, 64'h80);

    // SH lane placement, held while waiting
    nextCycle(); clearIn(); setMem(0, 3'b001, 64'h2006); in_wdata = 64'hABCD;
    for (int c = 0; c < 2; c++) begin
      observe();
      chk("sh strobe", 64'(dreq_strobe), 64'hC0);
      chk("sh data", dreq_data, 64'hABCD_0000_0000_0000);
      nextCycle();
    end
    dresp_data_ok = 1; observe(); chk("sh done stall", 64'(stall_req), 64'h0);

    // Misaligned LW
    nextCycle(); clearIn(); setMem(1, 3'b010, 64'h3002); observe();
    chk("lw misalign", 64'(out_misalign), 64'h1);
    chk("lw dreq_valid", 64'(dreq_valid), 64'h0);
    chk("lw out_valid", 64'(out_valid), 64'h1);
    chk("lw wdata", out_wdata, 64'h0);

    // LD completing under freeze, held for two more frozen cycles
    nextCycle(); clearIn(); setMem(1, 3'b011, 64'h4008);
    dresp_data = 64'h1122_3344_5566_7788; dresp_data_ok = 1; freeze = 1; observe();
    chk("ld wdata", out_wdata, 64'h1122_3344_5566_7788);
    for (int c = 0; c < 2; c++) begin
      nextCycle(); dresp_data_ok = 0; dresp_data = 64'hDEAD_BEEF_0000_0000; observe();
      chk("ld frozen dreq", 64'(dreq_valid), 64'h0);
      chk("ld frozen wdata", out_wdata, 64'h1122_3344_5566_7788);
      chk("ld frozen stall", 64'(stall_req), 64'h0);
    end
    nextCycle(); freeze = 0; observe();
    chk("ld release wdata", out_wdata, 64'h1122_3344_5566_7788);
    nextCycle(); setMem(1, 3'b000, 64'h4010); observe();
    chk("idle again dreq", 64'(dreq_valid), 64'h1);

    // Reset while waiting for a response
    nextCycle(); observe();
    reset = 1; clearIn(); haveCap = 0;
    #1 chk("reset in wait dreq", 64'(dreq_valid), 64'h0);
    nextCycle(); dresp_data_ok = 1; observe();
    nextCycle(); reset = 0; dresp_data_ok = 1; observe();
    chk("late ok out_valid", 64'(out_valid), 64'h0);
    nextCycle(); clearIn(); setMem(1, 3'b100, 64'h5001); dresp_data = 64'h0000_0000_0000_9A00;
    observe(); chk("post reset stall", 64'(stall_req), 64'h1);
    nextCycle(); dresp_data_ok = 1; observe();
    chk("post reset lbu", out_wdata, 64'h9A);

    // Randomized records with random latency and freeze
    for (int r = 0; r < 400; r++) begin
      logic [63:0] a;
      logic [2:0] f3;
      nextCycle(); clearIn();
      kind = int'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      f3 = 3'($urandom);
      if (kind == 2) f3[2] = 1'b0;
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nBytes(f3) - 1);
      lat = int'($urandom_range(0, 3));
      in_valid = (kind != 3); in_pc = {$urandom, $urandom}; in_rd = 5'($urandom);
      in_reg_write = 1'($urandom); in_result = {$urandom, $urandom};
      in_wdata = {$urandom, $urandom};
      if (kind == 1 || kind == 2) begin
        in_mem_read = (kind == 1); in_mem_write = (kind == 2); in_funct3 = f3; in_addr = a;
      end
      ok = (kind == 1 || kind == 2) && !isMisaligned(in_addr, in_funct3);
      k = 0;
      retire = 0;
      while (!retire && k < 60) begin
        if (k > 0) nextCycle();
        freeze = ($urandom_range(0, 3) == 0);
        dresp_data_ok = ok && (k == lat);
        dresp_data = {$urandom, $urandom};
        observe();
        k++;
      end
      if (!retire) chk("record retire", 64'h0, 64'h1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the in-order pipeline, sitting between the EX/MEM register and the MEM/WB register. It issues load/store requests on the data bus, holds them until the response, and generates byte strobes and store-data alignment. It also sign- or zero-extends load data and produces the next writeback record that the MEM/WB register latches every cycle. It raises a stall while a bus access is outstanding, and buffers a completed result if the rest of the pipeline is frozen.

## Interface
Parameters:
- none. Widths are fixed: XLEN = 64, register index = 5 bits.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM record valid.
- in_pc  in  64  instruction PC.
- in_mem_read, in_mem_write  in  1 each  load / store instruction. Never both asserted.
- in_funct3  in  3  RISC-V load/store funct3.
  - [1:0] = size: 0 = B, 1 = H, 2 = W, 3 = D.
  - [2] = unsigned (loads only).
- in_addr  in  64  effective address.
- in_wdata  in  64  store source, LSB-aligned.
- in_result  in  64  ALU result for non-load instructions.
- in_rd  in  5  destination register.
- in_reg_write  in  1  writes rd.
- freeze  in  1  pipeline-wide hold from another stage. The EX/MEM record stays unchanged while it is high.
- dreq_valid  out  1  bus request.
- dreq_addr  out  64  in_addr.
- dreq_size  out  3  {1'b0, in_funct3[1:0]}.
- dreq_strobe  out  8  byte-write mask. All zeros for loads.
- dreq_data  out  64  store data shifted into byte-lane position.
- dresp_data_ok  in  1  response valid, one cycle per request.
- dresp_data  in  64  aligned doubleword containing the addressed bytes.
- stall_req  out  1  memory stage not finished with the current record.
- out_valid  out  1  next MEM/WB record valid.
- out_pc, out_rd, out_reg_write  out  64/5/1  copies of the inputs.
- out_wdata  out  64  writeback value (extended load data or in_result).
- out_misalign  out  1  access address not naturally aligned for its size.

## Operation
- is_mem = in_valid & (in_mem_read | in_mem_write).
- misalign = is_mem & (in_addr & (size_bytes − 1)) != 0.
- Misaligned access:
  - No bus request is issued.
  - The record completes in the same cycle with out_misalign = 1, out_valid = 1 and out_wdata = 0.
- Store lane logic, with off = in_addr[2:0]:
  - dreq_strobe = ((1 << size_bytes) − 1) << off, truncated to 8 bits.
  - dreq_data = in_wdata << (8·off).
- Load extraction:
  - raw = dresp_data >> (8·off), truncated to the access size.
  - Sign-extended when funct3[2] = 0, zero-extended when funct3[2] = 1.
- out_wdata = buffered/extended load value for loads, in_result otherwise. Stores pass in_result.
- FSM states: IDLE, WAIT, DONE.
  - IDLE / WAIT:
    - dreq_valid = is_mem & !misalign.
    - If dresp_data_ok: the access is complete this cycle. The next state is DONE if freeze (the load value is latched into buf), else IDLE.
    - If not dresp_data_ok: the next state is WAIT.
    - A non-memory record stays in IDLE.
  - DONE:
    - dreq_valid = 0, so there is no reissue.
    - The access counts as complete, and out_wdata comes from buf.
    - Returns to IDLE on the first cycle freeze = 0.
- stall_req = is_mem & !misalign & !complete, where complete = dresp_data_ok or state == DONE.
- out_valid = in_valid & !stall_req.
- Non-memory records pass through combinationally. They have no state effect.

## Timing
- Reset (async):
  - state = IDLE, buf = 0.
  - dreq_valid is forced to 0 while reset is high.
  - All outputs derived from in_* are combinational, so they follow the inputs, which are 0 from the reset upstream register.
- Reset during WAIT abandons the access. No buffered result survives, and a late dresp_data_ok after reset in IDLE with in_valid = 0 is ignored.
- Request stability: dreq_addr, dreq_size, dreq_strobe and dreq_data stay constant from the first dreq_valid cycle until dresp_data_ok, because EX/MEM is held by stall_req.
- Latency:
  - Non-memory or misaligned records: 0 cycles.
  - Loads and stores: the cycle of dresp_data_ok. A same-cycle response (latency 0) is legal.
- freeze together with dresp_data_ok: the result is captured in buf. On the following cycles stall_req = 0, out_valid = 1 and dreq_valid = 0 until freeze drops.
- freeze during WAIT has no effect on the request.

## Test plan
- Add (in_result = 0x5, rd = 3), no mem:
  - Same cycle: out_valid = 1, out_wdata = 5, dreq_valid = 0, stall_req = 0.
- LB addr = 0x1003, dresp_data = 0x0000_0000_8000_0000 with data_ok on the 3rd cycle:
  - stall_req high for 2 cycles, then out_wdata = 0xFFFF_FFFF_FFFF_FF80.
  - Same address with LBU gives 0x80.
- SH addr = 0x2006, in_wdata = 0xABCD:
  - dreq_strobe = 0xC0, dreq_data = 0xABCD_0000_0000_0000, held until data_ok.
- LW addr = 0x3002:
  - out_misalign = 1, dreq_valid never asserted, out_valid = 1, no stall.
- LD with data_ok and freeze high for 2 more cycles:
  - dreq_valid = 0 and out_wdata = loaded value in both frozen cycles; the FSM is back in IDLE after freeze drops.
- Reset asserted in WAIT:
  - dreq_valid = 0 immediately and state = IDLE.
  - A subsequent data_ok pulse with in_valid = 0 produces no output.
